// File: rtl/trap_exit_sequencer.sv
// Ends a hypervisor trap: after exit_arm, waits for RETN/RETI (or optional RET) plus its stack pops, then pulses trap_exit.
// trap_exit rises on the clock after the final pop read completes; bus is only observed, never stalled.
module trap_exit_sequencer #(
  parameter int POP_READS        = 2,
  parameter bit ACCEPT_PLAIN_RET = 1'b0,
  parameter int TIMEOUT          = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic       refresh_n,
  input  logic       trap_state,
  input  logic       exit_arm,
  output logic       trap_exit,
  output logic       exit_busy,
  output logic       exit_error
);

  localparam int PW = (POP_READS > 0) ? $clog2(POP_READS + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] POP_LAST = PW'(POP_READS);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ARMED, PREFIX, POP, EXIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pop_cnt, pop_cnt_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          err_nxt;
  logic          rd_q, mem_q, m1_q;
  logic [7:0]    data_q;
  logic          rd_done, fetch, mem_rd, is_ret, is_plain_ret;

  // mem_q/m1_q remember what kind of cycle the current read strobe belongs to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= 1'b1;
      mem_q  <= 1'b0;
      m1_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      rd_q <= rd_n;
      if (!rd_n) begin
        mem_q <= !mreq_n && refresh_n;
        m1_q  <= !m1_n;
      end
      if (!mreq_n && !rd_n && refresh_n) data_q <= data;
    end
  end

  assign rd_done      = !rd_q && rd_n && mem_q;
  assign fetch        = rd_done && m1_q;
  assign mem_rd       = rd_done && !m1_q;
  assign is_ret       = (data_q[7:6] == 2'b01) && (data_q[2:0] == 3'b101);
  assign is_plain_ret = ACCEPT_PLAIN_RET && (data_q == 8'hC9);

  always_comb begin
    state_nxt   = state;
    pop_cnt_nxt = pop_cnt;
    tmo_nxt     = '0;
    err_nxt     = exit_error && !exit_arm;
    if (state != EXIT && !trap_state) begin
      state_nxt   = IDLE;
      pop_cnt_nxt = '0;
    end else if (exit_arm && trap_state) begin
      state_nxt   = ARMED;
      pop_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          if (fetch && data_q == 8'hED) begin
            state_nxt = PREFIX;
          end else if (fetch && is_plain_ret) begin
            pop_cnt_nxt = '0;
            if (POP_READS == 0) state_nxt = EXIT;
            else                state_nxt = POP;
          end
        end
        PREFIX: begin
          if (tmo == TMO_MAX) begin
            err_nxt   = 1'b1;
            state_nxt = ARMED;
          end else if (fetch) begin
            if (is_ret) begin
              pop_cnt_nxt = '0;
              if (POP_READS == 0) state_nxt = EXIT;
              else                state_nxt = POP;
            end else if (data_q != 8'hED) begin
              state_nxt = ARMED;
            end
          end else if (!mem_rd) begin
            tmo_nxt = tmo + TW'(1);
          end
        end
        POP: begin
          if (tmo == TMO_MAX) begin
            err_nxt     = 1'b1;
            state_nxt   = ARMED;
            pop_cnt_nxt = '0;
          end else if (fetch) begin
            // an opcode fetch means the return did not happen as expected
            state_nxt   = ARMED;
            pop_cnt_nxt = '0;
          end else if (mem_rd) begin
            if (pop_cnt + PW'(1) == POP_LAST) begin
              state_nxt   = EXIT;
              pop_cnt_nxt = '0;
            end else begin
              pop_cnt_nxt = pop_cnt + PW'(1);
            end
          end else begin
            tmo_nxt = tmo + TW'(1);
          end
        end
        EXIT:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pop_cnt    <= '0;
      tmo        <= '0;
      exit_error <= 1'b0;
      trap_exit  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pop_cnt    <= pop_cnt_nxt;
      tmo        <= tmo_nxt;
      exit_error <= err_nxt;
      trap_exit  <= (state_nxt == EXIT);
    end
  end

  assign exit_busy = (state != IDLE);

endmodule

// File: tb/tb_trap_exit_sequencer.sv
// Bench for trap_exit_sequencer: directed protocol steps then random bus traffic, against a transaction-level model.
module tb_trap_exit_sequencer;

  localparam int POPS     = 2;
  localparam int TMO      = 15;
  localparam int EV_NONE  = 0;
  localparam int EV_FETCH = 1;
  localparam int EV_MEMRD = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data;
  logic       m1_n, mreq_n, rd_n, refresh_n, trap_state, exit_arm;
  logic       te0, eb0, ee0, te1, eb1, ee1;

  int n_chk  = 0;
  int n_pass = 0;
  bit arm_on_cmp = 1'b0;

  // model: waiting-for-return flag, prefix seen, pops still owed (-1 = none), clocks since last event
  bit m_act[2], m_pref[2], m_pulse[2], m_err[2], acc[2];
  int m_pops[2], m_since[2];

  trap_exit_sequencer #(.POP_READS(POPS), .ACCEPT_PLAIN_RET(1'b0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset_n(reset_n), .data(data), .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n),
    .refresh_n(refresh_n), .trap_state(trap_state), .exit_arm(exit_arm),
    .trap_exit(te0), .exit_busy(eb0), .exit_error(ee0));

  trap_exit_sequencer #(.POP_READS(POPS), .ACCEPT_PLAIN_RET(1'b1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset_n(reset_n), .data(data), .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n),
    .refresh_n(refresh_n), .trap_state(trap_state), .exit_arm(exit_arm),
    .trap_exit(te1), .exit_busy(eb1), .exit_error(ee1));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic obs, logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pref[i] = 0; m_pulse[i] = 0; m_err[i] = 0;
      m_pops[i] = -1; m_since[i] = 0;
    end
  endtask

  task automatic finish_ret(int i);
    m_pulse[i] = 1; m_act[i] = 0; m_pops[i] = -1; m_pref[i] = 0;
  endtask

  task automatic start_pops(int i);
    m_pops[i] = POPS;
    m_since[i] = 0;
    if (m_pops[i] == 0) finish_ret(i);
  endtask

  task automatic model_step(int i, int ev, logic [7:0] op, logic arm, logic ts);
    bit was_pulse;
    was_pulse = m_pulse[i];
    m_pulse[i] = 0;
    if (arm) m_err[i] = 0;
    if (!ts && !was_pulse) begin
      m_act[i] = 0; m_pref[i] = 0; m_pops[i] = -1; m_since[i] = 0;
      return;
    end
    if (arm && ts) begin
      m_act[i] = 1; m_pref[i] = 0; m_pops[i] = -1; m_since[i] = 0;
      return;
    end
    if (!m_act[i]) return;
    if (m_pref[i] || m_pops[i] >= 0) begin
      m_since[i]++;
      if (m_since[i] > TMO) begin
        m_err[i] = 1; m_pref[i] = 0; m_pops[i] = -1; m_since[i] = 0;
        return;
      end
    end
    if (ev == EV_FETCH) begin
      m_since[i] = 0;
      if (m_pops[i] >= 0) m_pops[i] = -1;
      else if (m_pref[i] && (op inside {8'h45, 8'h4D, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D})) begin
        m_pref[i] = 0;
        start_pops(i);
      end
      else if (op == 8'hED) m_pref[i] = 1;
      else if (!m_pref[i] && op == 8'hC9 && acc[i]) start_pops(i);
      else m_pref[i] = 0;
    end else if (ev == EV_MEMRD) begin
      m_since[i] = 0;
      if (m_pops[i] > 0) begin
        m_pops[i]--;
        if (m_pops[i] == 0) finish_ret(i);
      end
    end
  endtask

  task automatic tick(int ev, logic [7:0] op);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, ev, op, exit_arm, trap_state);
    #1;
    chk("trap_exit0", te0, m_pulse[0]);
    chk("exit_busy0", eb0, m_act[0] | m_pulse[0]);
    chk("exit_error0", ee0, m_err[0]);
    chk("trap_exit1", te1, m_pulse[1]);
    chk("exit_busy1", eb1, m_act[1] | m_pulse[1]);
    chk("exit_error1", ee1, m_err[1]);
    exit_arm = 1'b0;
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  task automatic bus(logic m1, logic mreq, logic rd, logic rf, logic [7:0] d);
    m1_n = m1; mreq_n = mreq; rd_n = rd; refresh_n = rf; data = d;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick(EV_NONE, 8'h00);
  endtask

  task automatic arm();
    exit_arm = 1'b1;
    tick(EV_NONE, 8'h00);
  endtask

  task automatic fetch(logic [7:0] op);
    bus(0, 0, 0, 1, op); idle(2);
    bus(1, 1, 1, 1, 8'hFF);
    if (arm_on_cmp) exit_arm = 1'b1;
    arm_on_cmp = 1'b0;
    tick(EV_FETCH, op);
    bus(1, 0, 1, 0, rnd()); idle(2);
    bus(1, 1, 1, 1, 8'hFF);
  endtask

  task automatic memrd(logic [7:0] d);
    bus(1, 0, 0, 1, d); idle(2);
    bus(1, 1, 1, 1, 8'hFF);
    if (arm_on_cmp) exit_arm = 1'b1;
    arm_on_cmp = 1'b0;
    tick(EV_MEMRD, d);
  endtask

  task automatic refresh();
    bus(1, 0, 1, 0, rnd()); idle(2);
    bus(1, 1, 1, 1, 8'hFF);
  endtask

  task automatic ioread();
    bus(1, 1, 0, 1, rnd()); idle(2);
    bus(1, 1, 1, 1, 8'hFF); idle(1);
  endtask

  task automatic intack();
    bus(0, 1, 1, 1, rnd()); idle(2);
    bus(1, 1, 1, 1, 8'hFF); idle(1);
  endtask

  initial begin
    int r;
    logic [7:0] rop;
    acc[0] = 1'b0;
    acc[1] = 1'b1;
    model_reset();
    reset_n = 1'b0; trap_state = 1'b0; exit_arm = 1'b0;
    bus(1, 1, 1, 1, 8'hFF);
    #12;
    chk("rst_trap_exit", te0, 1'b0);
    chk("rst_busy", eb0, 1'b0);
    chk("rst_error", ee1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    trap_state = 1'b1;

    // basic RETN exit
    arm(); chk("armed_busy", eb0, 1'b1);
    fetch(8'hED); fetch(8'h45); memrd(rnd()); memrd(rnd());
    chk("retn_pulse", te0, 1'b1);
    tick(EV_NONE, 8'h00);
    chk("pulse_one_clk", te0, 1'b0);
    chk("idle_after_exit", eb0, 1'b0);

    // ED B0 is not a return; then RETI
    arm(); fetch(8'hED); fetch(8'hB0);
    chk("ldir_busy", eb0, 1'b1);
    fetch(8'hED); fetch(8'h4D); memrd(rnd()); memrd(rnd());
    chk("reti_pulse", te0, 1'b1);
    tick(EV_NONE, 8'h00);

    // timeout after one pop, cleared by re-arm; then a gap of exactly TMO is tolerated
    arm(); fetch(8'hED); fetch(8'h45); memrd(rnd()); idle(TMO + 1);
    chk("tmo_error", ee0, 1'b1);
    chk("tmo_armed", eb0, 1'b1);
    arm(); chk("arm_clears_err", ee0, 1'b0);
    fetch(8'hED); fetch(8'h45); memrd(rnd()); idle(TMO - 3); memrd(rnd());
    chk("tmo_edge_pulse", te0, 1'b1);
    chk("tmo_edge_noerr", ee0, 1'b0);
    tick(EV_NONE, 8'h00);

    // no arm: no exit; plain RET only when accepted
    fetch(8'hED); fetch(8'h45); memrd(rnd()); memrd(rnd());
    chk("unarmed_nopulse", te0, 1'b0);
    arm(); fetch(8'hC9); memrd(rnd()); memrd(rnd());
    chk("c9_rejected", te0, 1'b0);
    chk("c9_accepted", te1, 1'b1);
    tick(EV_NONE, 8'h00);

    // refresh between pops; trap_state drop; arm coinciding with final pop
    arm(); fetch(8'hED); fetch(8'h45); memrd(rnd()); refresh(); refresh(); memrd(rnd());
    chk("rfsh_pulse", te0, 1'b1);
    tick(EV_NONE, 8'h00);
    arm(); fetch(8'hED); fetch(8'h45); memrd(rnd());
    trap_state = 1'b0; tick(EV_NONE, 8'h00);
    chk("drop_idle", eb0, 1'b0);
    trap_state = 1'b1; memrd(rnd());
    chk("drop_nopulse", te0, 1'b0);
    arm(); fetch(8'hED); fetch(8'h45); memrd(rnd());
    arm_on_cmp = 1'b1; memrd(rnd());
    chk("arm_wins_nopulse", te0, 1'b0);
    chk("arm_wins_busy", eb0, 1'b1);

    // async reset mid-pop with the error flag set
    fetch(8'hED); fetch(8'h45); idle(TMO + 1);
    chk("pre_rst_error", ee0, 1'b1);
    fetch(8'hED); fetch(8'h45); memrd(rnd());
    bus(1, 0, 0, 1, rnd()); tick(EV_NONE, 8'h00);
    #2 reset_n = 1'b0;
    bus(1, 1, 1, 1, 8'hFF);
    #1;
    model_reset();
    chk("async_rst_busy", eb0, 1'b0);
    chk("async_rst_error", ee0, 1'b0);
    chk("async_rst_exit", te0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    fetch(8'hED); fetch(8'h45); memrd(rnd()); memrd(rnd());
    chk("post_rst_nopulse", te0, 1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!trap_state && $urandom_range(0, 3) == 0) trap_state = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 8) arm();
      else if (r < 10) begin trap_state = 1'b0; tick(EV_NONE, 8'h00); end
      else if (r < 12) arm_on_cmp = 1'b1;
      else if (r < 27) fetch(8'hED);
      else if (r < 39) begin rop = {2'b01, 3'($urandom_range(0, 7)), 3'b101}; fetch(rop); end
      else if (r < 45) fetch(8'hC9);
      else if (r < 53) fetch(rnd());
      else if (r < 75) memrd(rnd());
      else if (r < 80) refresh();
      else if (r < 84) ioread();
      else if (r < 87) intack();
      else idle($urandom_range(1, 20));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
